// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse position tracker.
// Byte-0 bit positions, default screen extents and the header decode helper.
package mouse_pkg;

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2,
        APPLY
    } state_e;

    localparam int unsigned BTN_L = 0;
    localparam int unsigned BTN_R = 1;
    localparam int unsigned BTN_M = 2;
    localparam int unsigned SYNC  = 3;
    localparam int unsigned XS    = 4;
    localparam int unsigned YS    = 5;
    localparam int unsigned XO    = 6;
    localparam int unsigned YO    = 7;

    localparam int unsigned H_MAX_DEFAULT = 640;
    localparam int unsigned V_MAX_DEFAULT = 480;

    // Byte 0 minus the always-one sync bit, which carries no information once accepted.
    typedef struct packed {
        logic y_ovf;
        logic x_ovf;
        logic y_sign;
        logic x_sign;
        logic btn_m;
        logic btn_r;
        logic btn_l;
    } hdr_t;

    function automatic hdr_t decode_hdr(input logic [7:0] b);
        hdr_t h;
        h.y_ovf  = b[YO];
        h.x_ovf  = b[XO];
        h.y_sign = b[YS];
        h.x_sign = b[XS];
        h.btn_m  = b[BTN_M];
        h.btn_r  = b[BTN_R];
        h.btn_l  = b[BTN_L];
        return h;
    endfunction

endpackage

// File: rtl/mouse_axis_clamp.sv
// Saturating add of a signed delta to an unsigned screen coordinate.
// Result is clamped to [0, LIMIT-1]; the sum is formed in 12-bit signed so it never wraps.
module mouse_axis_clamp #(
    parameter int unsigned LIMIT = 640
) (
    input  logic [9:0]        pos_i,
    input  logic signed [9:0] delta_i,
    output logic [9:0]        pos_o
);

    localparam logic signed [11:0] MaxPos = 12'(LIMIT - 1);

    logic signed [11:0] sum;

    always_comb begin
        sum = $signed({2'b00, pos_i}) + $signed({{2{delta_i[9]}}, delta_i});
        if (sum < 12'sd0) begin
            pos_o = '0;
        end else if (sum > MaxPos) begin
            pos_o = MaxPos[9:0];
        end else begin
            pos_o = sum[9:0];
        end
    end

endmodule

// File: rtl/mouse_pos_tracker.sv
// Assembles 3-byte PS/2 mouse packets and tracks a clamped absolute cursor position.
// Produces button levels plus one-cycle click, update and sync-error pulses.
module mouse_pos_tracker
    import mouse_pkg::*;
#(
    parameter int unsigned H_MAX       = H_MAX_DEFAULT,
    parameter int unsigned V_MAX       = V_MAX_DEFAULT,
    parameter int unsigned X_INIT      = 320,
    parameter int unsigned Y_INIT      = 240,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [9:0] mouse_x_pos,
    output logic [9:0] mouse_y_pos,
    output logic       mouse_left,
    output logic       mouse_right,
    output logic       mouse_middle,
    output logic       left_click,
    output logic       right_click,
    output logic       pos_update,
    output logic       sync_err
);

    localparam int unsigned     CntW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    state_e          state_q, state_d;
    hdr_t            hdr_q, hdr_d;
    logic [7:0]      dx_q, dx_d, dy_q, dy_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [9:0]      x_q, x_d, y_q, y_d;
    logic            left_q, left_d, right_q, right_d, middle_q, middle_d;
    logic            lclk_q, lclk_d, rclk_q, rclk_d, upd_q, upd_d, serr_q, serr_d;

    logic signed [9:0] dx_ext, dy_neg;
    logic [9:0]        x_clamped, y_clamped;
    logic              b0_slot, timeout;

    // Overflowed axes contribute nothing; Y is negated because PS/2 +Y points up.
    assign dx_ext = hdr_q.x_ovf ? '0 : {hdr_q.x_sign, hdr_q.x_sign, dx_q};
    assign dy_neg = hdr_q.y_ovf ? '0 : -{hdr_q.y_sign, hdr_q.y_sign, dy_q};

    mouse_axis_clamp #(.LIMIT(H_MAX)) u_clamp_x (
        .pos_i  (x_q),
        .delta_i(dx_ext),
        .pos_o  (x_clamped)
    );

    mouse_axis_clamp #(.LIMIT(V_MAX)) u_clamp_y (
        .pos_i  (y_q),
        .delta_i(dy_neg),
        .pos_o  (y_clamped)
    );

    // A byte arriving during APPLY is the next packet's byte 0, so it gets the same check.
    assign b0_slot = rx_valid && (state_q == WAIT_B0 || state_q == APPLY);
    assign timeout = (cnt_q == CntLast);

    always_comb begin
        state_d  = state_q;
        hdr_d    = hdr_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        left_d   = left_q;
        right_d  = right_q;
        middle_d = middle_q;
        lclk_d   = 1'b0;
        rclk_d   = 1'b0;
        upd_d    = 1'b0;
        serr_d   = 1'b0;

        unique case (state_q)
            WAIT_B0: ;
            WAIT_B1, WAIT_B2: begin
                if (rx_valid) begin
                    cnt_d = '0;
                    if (state_q == WAIT_B1) begin
                        dx_d    = rx_data;
                        state_d = WAIT_B2;
                    end else begin
                        dy_d    = rx_data;
                        state_d = APPLY;
                    end
                end else if (timeout) begin
                    cnt_d   = '0;
                    serr_d  = 1'b1;
                    state_d = WAIT_B0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            APPLY: begin
                x_d      = x_clamped;
                y_d      = y_clamped;
                left_d   = hdr_q.btn_l;
                right_d  = hdr_q.btn_r;
                middle_d = hdr_q.btn_m;
                lclk_d   = hdr_q.btn_l & ~left_q;
                rclk_d   = hdr_q.btn_r & ~right_q;
                upd_d    = 1'b1;
                state_d  = WAIT_B0;
            end
            default: state_d = WAIT_B0;
        endcase

        if (b0_slot) begin
            if (rx_data[SYNC]) begin
                hdr_d   = decode_hdr(rx_data);
                cnt_d   = '0;
                state_d = WAIT_B1;
            end else begin
                serr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT_B0;
            hdr_q    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            cnt_q    <= '0;
            x_q      <= 10'(X_INIT);
            y_q      <= 10'(Y_INIT);
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            middle_q <= 1'b0;
            lclk_q   <= 1'b0;
            rclk_q   <= 1'b0;
            upd_q    <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            left_q   <= left_d;
            right_q  <= right_d;
            middle_q <= middle_d;
            lclk_q   <= lclk_d;
            rclk_q   <= rclk_d;
            upd_q    <= upd_d;
            serr_q   <= serr_d;
        end
    end

    assign mouse_x_pos  = x_q;
    assign mouse_y_pos  = y_q;
    assign mouse_left   = left_q;
    assign mouse_right  = right_q;
    assign mouse_middle = middle_q;
    assign left_click   = lclk_q;
    assign right_click  = rclk_q;
    assign pos_update   = upd_q;
    assign sync_err     = serr_q;

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Self-checking bench for mouse_pos_tracker: packet-level reference model compared every cycle,
// plus hand-computed literal expectations for each directed scenario.
module tb_mouse_pos_tracker;

    localparam int T = 40;  // shortened packet timeout

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [9:0] mouse_x_pos, mouse_y_pos;
    logic       mouse_left, mouse_right, mouse_middle;
    logic       left_click, right_click, pos_update, sync_err;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    mouse_pos_tracker #(
        .H_MAX      (640),
        .V_MAX      (480),
        .X_INIT     (320),
        .Y_INIT     (240),
        .TIMEOUT_CYC(T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .mouse_x_pos (mouse_x_pos),
        .mouse_y_pos (mouse_y_pos),
        .mouse_left  (mouse_left),
        .mouse_right (mouse_right),
        .mouse_middle(mouse_middle),
        .left_click  (left_click),
        .right_click (right_click),
        .pos_update  (pos_update),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: packet bytes gathered in a queue, applied one cycle after completion.
    logic [7:0] pkt[$];
    logic [7:0] pend_pkt[3];
    bit         pend;
    int         idle;
    int         m_x, m_y;
    bit         m_l, m_r, m_m, m_lc, m_rc, m_pu, m_se;

    function automatic int clampf(input int v, input int lim);
        if (v < 0) return 0;
        if (v > lim - 1) return lim - 1;
        return v;
    endfunction

    function automatic int delta9(input bit sgn, input logic [7:0] b, input bit ovf);
        if (ovf) return 0;
        return sgn ? int'(b) - 256 : int'(b);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt.delete();
            pend = 0; idle = 0;
            m_x = 320; m_y = 240;
            {m_l, m_r, m_m, m_lc, m_rc, m_pu, m_se} = '0;
        end else begin
            {m_lc, m_rc, m_pu, m_se} = '0;
            if (pend) begin
                m_x  = clampf(m_x + delta9(pend_pkt[0][4], pend_pkt[1], pend_pkt[0][6]), 640);
                m_y  = clampf(m_y - delta9(pend_pkt[0][5], pend_pkt[2], pend_pkt[0][7]), 480);
                m_lc = pend_pkt[0][0] && !m_l;
                m_rc = pend_pkt[0][1] && !m_r;
                m_l  = pend_pkt[0][0];
                m_r  = pend_pkt[0][1];
                m_m  = pend_pkt[0][2];
                m_pu = 1;
                pend = 0;
            end
            if (rx_valid) begin
                if (pkt.size() == 0 && !rx_data[3]) begin
                    m_se = 1;
                end else begin
                    pkt.push_back(rx_data);
                    idle = 0;
                    if (pkt.size() == 3) begin
                        for (int i = 0; i < 3; i++) pend_pkt[i] = pkt[i];
                        pend = 1;
                        pkt.delete();
                    end
                end
            end else if (pkt.size() != 0) begin
                idle++;
                if (idle >= T) begin
                    pkt.delete();
                    m_se = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("model_x", 16'(mouse_x_pos), 16'(m_x));
            chk("model_y", 16'(mouse_y_pos), 16'(m_y));
            chk("model_left", 16'(mouse_left), 16'(m_l));
            chk("model_right", 16'(mouse_right), 16'(m_r));
            chk("model_middle", 16'(mouse_middle), 16'(m_m));
            chk("model_lclick", 16'(left_click), 16'(m_lc));
            chk("model_rclick", 16'(right_click), 16'(m_rc));
            chk("model_update", 16'(pos_update), 16'(m_pu));
            chk("model_syncerr", 16'(sync_err), 16'(m_se));
        end
    end

    // One clock cycle of stimulus; returns 1 time unit after the edge that sampled it.
    task automatic cyc(input logic v, input logic [7:0] b);
        rx_valid = v;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic pkt3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        cyc(1'b1, b0);
        cyc(1'b1, b1);
        cyc(1'b1, b2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst      = 1'b0;
        #2 rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_x", 16'(mouse_x_pos), 16'd320);
        chk("reset_y", 16'(mouse_y_pos), 16'd240);
        chk("reset_pulses", 16'({left_click, right_click, pos_update, sync_err}), 16'd0);
        chk("reset_buttons", 16'({mouse_left, mouse_right, mouse_middle}), 16'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Basic +X move and latency.
        pkt3(8'h08, 8'h10, 8'h00);
        chk("lat_x_not_yet", 16'(mouse_x_pos), 16'd320);
        chk("lat_upd_not_yet", 16'(pos_update), 16'd0);
        cyc(1'b0, 8'h00);
        chk("p1_x", 16'(mouse_x_pos), 16'd336);
        chk("p1_y", 16'(mouse_y_pos), 16'd240);
        chk("p1_update", 16'(pos_update), 16'd1);
        chk("p1_lclick", 16'(left_click), 16'd0);
        cyc(1'b0, 8'h00);
        chk("p1_update_end", 16'(pos_update), 16'd0);

        // Full negative X delta, clamp at left edge, left click only on first press.
        do_reset();
        pkt3(8'h19, 8'h00, 8'h00);
        cyc(1'b0, 8'h00);
        chk("neg_x1", 16'(mouse_x_pos), 16'd64);
        chk("neg_lclick1", 16'(left_click), 16'd1);
        chk("neg_left1", 16'(mouse_left), 16'd1);
        pkt3(8'h19, 8'h00, 8'h00);
        cyc(1'b0, 8'h00);
        chk("neg_x2_clamped", 16'(mouse_x_pos), 16'd0);
        chk("neg_lclick2", 16'(left_click), 16'd0);
        chk("neg_left2", 16'(mouse_left), 16'd1);

        // Y direction: PS/2 down (negative) moves screen Y up in value.
        do_reset();
        pkt3(8'h28, 8'h00, 8'hF6);
        cyc(1'b0, 8'h00);
        chk("y_down", 16'(mouse_y_pos), 16'd250);
        pkt3(8'h08, 8'h00, 8'h7F);
        cyc(1'b0, 8'h00);
        chk("y_up", 16'(mouse_y_pos), 16'd123);

        // Resync on a byte without the sync bit.
        do_reset();
        cyc(1'b1, 8'h00);
        chk("resync_err", 16'(sync_err), 16'd1);
        pkt3(8'h08, 8'h05, 8'h00);
        cyc(1'b0, 8'h00);
        chk("resync_x", 16'(mouse_x_pos), 16'd325);

        // Timeout drops the partial packet.
        do_reset();
        cyc(1'b1, 8'h08);
        cyc(1'b1, 8'h05);
        repeat (T) cyc(1'b0, 8'h00);
        chk("timeout_err", 16'(sync_err), 16'd1);
        pkt3(8'h08, 8'h01, 8'h00);
        cyc(1'b0, 8'h00);
        chk("timeout_x", 16'(mouse_x_pos), 16'd321);
        chk("timeout_y", 16'(mouse_y_pos), 16'd240);

        // X overflow plus next byte 0 strobed during APPLY.
        do_reset();
        pkt3(8'h4A, 8'hFF, 8'h03);
        cyc(1'b1, 8'h08);
        chk("ovf_x", 16'(mouse_x_pos), 16'd320);
        chk("ovf_y", 16'(mouse_y_pos), 16'd237);
        chk("ovf_right", 16'(mouse_right), 16'd1);
        chk("ovf_rclick", 16'(right_click), 16'd1);
        cyc(1'b1, 8'h02);
        cyc(1'b1, 8'h00);
        cyc(1'b0, 8'h00);
        chk("b2b_x", 16'(mouse_x_pos), 16'd322);
        chk("b2b_right", 16'(mouse_right), 16'd0);
        chk("b2b_update", 16'(pos_update), 16'd1);

        repeat (3) cyc(1'b0, 8'h00);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
